// File: rtl/register_file.sv
// register_file: parametrised register array with one write port and two combinational read ports
`ifndef POS_EDGE
`define POS_EDGE 1'b1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 1'b0
`endif
module register_file #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter bit active_edge = `POS_EDGE,
  parameter bit zero_reg = 1'b0,
  parameter bit bypass = 1'b1,
  localparam int AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [width-1:0] D,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  output logic [width-1:0] QA,
  output logic [width-1:0] QB
);
  localparam logic [AW:0] DEP = (AW+1)'(depth);
  logic [width-1:0] r_mem [depth];
  logic w_clk, w_wv, w_a_ok, w_b_ok;
  assign w_clk = active_edge ? clk : ~clk;
  assign w_wv = we && ({1'b0, wa} < DEP) && !(zero_reg && wa == '0);
  assign w_a_ok = ({1'b0, ra} < DEP) && !(zero_reg && ra == '0);
  assign w_b_ok = ({1'b0, rb} < DEP) && !(zero_reg && rb == '0);
  // storage update on the selected edge: reset beats write beats hold
  always_ff @(posedge w_clk) begin
    if (rst)
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    else if (w_wv)
      r_mem[wa] <= D;
  end
  // read ports: out-of-range and zero register read 0, bypass forwards D unless in reset
  always_comb begin
    QA = !w_a_ok ? '0 : (bypass && w_wv && !rst && wa == ra) ? D : r_mem[ra];
    QB = !w_b_ok ? '0 : (bypass && w_wv && !rst && wa == rb) ? D : r_mem[rb];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of three register_file configurations
`ifndef POS_EDGE
`define POS_EDGE 1'b1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 1'b0
`endif
module tb_register_file;
  logic clk = 0, rst = 0, we = 0;
  logic [2:0] wa = 0, ra = 0, rb = 0;
  logic [7:0] D = 0;
  logic [7:0] qa [3];
  logic [7:0] qb [3];
  logic [7:0] m [3][8];
  int dep [3] = '{4, 4, 5};
  bit byp [3] = '{0, 1, 0};
  bit zr [3] = '{0, 1, 0};
  int errs = 0, checks = 0;
  bit en = 0;
  always #5 clk = ~clk;
  register_file #(.width(8), .depth(4), .active_edge(`POS_EDGE), .zero_reg(1'b0), .bypass(1'b0)) u0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa[1:0]), .D(D), .ra(ra[1:0]), .rb(rb[1:0]), .QA(qa[0]), .QB(qb[0]));
  register_file #(.width(8), .depth(4), .active_edge(`POS_EDGE), .zero_reg(1'b1), .bypass(1'b1)) u1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa[1:0]), .D(D), .ra(ra[1:0]), .rb(rb[1:0]), .QA(qa[1]), .QB(qb[1]));
  register_file #(.width(8), .depth(5), .active_edge(`NEG_EDGE), .zero_reg(1'b0), .bypass(1'b0)) u2 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .D(D), .ra(ra), .rb(rb), .QA(qa[2]), .QB(qb[2]));
  function automatic logic [2:0] adr(int k, logic [2:0] a);
    return k < 2 ? {1'b0, a[1:0]} : a;
  endfunction
  function automatic bit ok(int k, logic [2:0] a);
    logic [2:0] x = adr(k, a);
    return int'(x) < dep[k] && !(zr[k] && x == 0);
  endfunction
  function automatic logic [7:0] exp_rd(int k, logic [2:0] a);
    logic [2:0] x = adr(k, a);
    if (!ok(k, a)) return 8'h00;
    if (byp[k] && we && !rst && ok(k, wa) && adr(k, wa) == x) return D;
    return m[k][x];
  endfunction
  task automatic upd(int k);
    if (rst) for (int i = 0; i < 8; i++) m[k][i] = 8'h00;
    else if (we && ok(k, wa)) m[k][adr(k, wa)] = D;
  endtask
  always @(posedge clk or negedge clk)
    if (clk) begin
      upd(0);
      upd(1);
    end else upd(2);
  task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  task automatic cmp(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_qa%0d", tag, k), qa[k], exp_rd(k, ra));
      chk($sformatf("%s_qb%0d", tag, k), qb[k], exp_rd(k, rb));
    end
  endtask
  initial forever begin
    @(negedge clk);
    #3;
    if (en) cmp("pre");
    #3;
    if (en) cmp("post");
  end
  task automatic drive(bit r, bit w, logic [2:0] a, logic [7:0] d, logic [2:0] x, logic [2:0] y);
    @(negedge clk);
    #2;
    rst = r; we = w; wa = a; D = d; ra = x; rb = y;
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    en = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 3'(i), 3'(3 - i));
      #2 chk("rst_qa", qa[0], 8'h00); chk("rst_qb", qb[0], 8'h00);
    end
    drive(0, 1, 2, 8'hA5, 2, 1);
    #2 chk("pre_wr", qa[0], 8'h00); chk("byp_pre", qa[1], 8'hA5);
    #4 chk("neg_rise", qa[2], 8'h00);
    drive(0, 1, 1, 8'h3C, 2, 1);
    #2 chk("wb_a", qa[0], 8'hA5); chk("wb_b_nobyp", qb[0], 8'h00); chk("neg_fall", qa[2], 8'hA5);
    drive(0, 0, 0, 0, 2, 1);
    #2 chk("wb_b", qb[0], 8'h3C);
    drive(0, 1, 3, 8'h11, 3, 3);
    drive(0, 1, 3, 8'h77, 3, 3);
    #2 chk("byp_a", qa[1], 8'h77); chk("byp_b", qb[1], 8'h77); chk("nobyp_old", qa[0], 8'h11);
    #4 chk("byp_after", qa[1], 8'h77); chk("nobyp_after", qa[0], 8'h77);
    drive(0, 0, 0, 0, 2, 3);
    #2 chk("byp_other", qa[1], 8'hA5);
    drive(0, 1, 0, 8'hFF, 0, 0);
    #2 chk("zero_pre", qa[1], 8'h00);
    #4 chk("zero_post", qa[1], 8'h00); chk("nozero_post", qa[0], 8'hFF);
    drive(0, 1, 1, 8'hFF, 1, 1);
    #6 chk("zero_r1", qa[1], 8'hFF);
    drive(0, 1, 1, 8'h22, 1, 1);
    drive(1, 1, 1, 8'h55, 1, 1);
    #2 chk("rst_nobyp", qa[1], 8'h22);
    drive(0, 0, 0, 0, 1, 1);
    #2 chk("rst_pri0", qa[0], 8'h00); chk("rst_pri1", qa[1], 8'h00); chk("rst_pri2", qa[2], 8'h00);
    drive(0, 1, 6, 8'h99, 6, 7);
    #2 chk("oob_a", qa[2], 8'h00); chk("oob_b", qb[2], 8'h00);
    drive(0, 1, 4, 8'h44, 4, 6);
    drive(0, 0, 0, 0, 4, 6);
    #2 chk("d5_top", qa[2], 8'h44); chk("d5_oob", qb[2], 8'h00);
    drive(0, 0, 0, 0, 1, 1);
    @(negedge clk); #2 we = 1; wa = 1; D = 8'h0F;
    @(posedge clk); #2 we = 0;
    @(negedge clk); #2 chk("neg_we_rise", qa[2], 8'h00); chk("pos_we_rise", qa[0], 8'h0F);
    @(posedge clk); #2 we = 1; wa = 1; D = 8'h0F;
    @(negedge clk); #2 we = 0;
    #1 chk("neg_we_fall", qa[2], 8'h0F);
    @(negedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk); #2 chk("neg_rst_rise", qa[2], 8'h0F); chk("pos_rst_rise", qa[0], 8'h00);
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
